imem_fetch_pipe: RTL

Parametrised instruction memory with a pipelined, flow-controlled fetch port, sitting between the fetch stage's PC and the decoder. It holds DEPTH words of DATA_W bits, accepts one byte-address fetch request per cycle, and returns the instruction after a configurable READ_LAT. It also provides a word-write load port for program loading, a flush for branch redirects, and a fault flag for misaligned or out-of-range PCs.

---
 rtl/imem_fetch_pipe_if.sv | 40 ++++
 rtl/imem_fetch_pipe.sv | 107 ++++++++++
 2 files changed

// File: rtl/imem_fetch_pipe_if.sv
// Fetch-port bundle between the fetch stage (master) and the instruction memory (slave).
// The request side carries a byte PC. The response side returns the instruction, its PC
// and a fault flag.
interface imem_fetch_pipe_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned PC_W   = 32
);
    logic              req_valid;
    logic              req_ready;
    logic [PC_W-1:0]   req_pc;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_instr;
    logic [PC_W-1:0]   rsp_pc;
    logic              rsp_fault;

    // Fetch stage side
    modport master (
        output req_valid,
        output req_pc,
        output rsp_ready,
        input  req_ready,
        input  rsp_valid,
        input  rsp_instr,
        input  rsp_pc,
        input  rsp_fault
    );

    // Instruction memory side
    modport slave (
        input  req_valid,
        input  req_pc,
        input  rsp_ready,
        output req_ready,
        output rsp_valid,
        output rsp_instr,
        output rsp_pc,
        output rsp_fault
    );
endinterface

// File: rtl/imem_fetch_pipe.sv
// Instruction memory with a READ_LAT-deep, flow-controlled fetch pipeline.
// The array is read when a request is accepted. The result then travels through
// READ_LAT register stages. The last stage drives the response outputs.
// Word loads take priority over fetches. Flush drops everything that is in flight.
module imem_fetch_pipe #(
    parameter int unsigned       DATA_W   = 32,
    parameter int unsigned       DEPTH    = 64,
    parameter int unsigned       PC_W     = 32,
    parameter int unsigned       READ_LAT = 1,
    parameter logic [DATA_W-1:0] NOP_WORD = '0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    imem_fetch_pipe_if.slave         bus,
    input  logic                     flush,
    input  logic                     ld_en,
    input  logic [$clog2(DEPTH)-1:0] ld_addr,
    input  logic [DATA_W-1:0]        ld_data
);

    localparam int unsigned IdxW = $clog2(DEPTH);

    // Instruction storage; deliberately not reset, contents come from the load port.
    logic [DATA_W-1:0] mem_q [DEPTH];

    // Pipeline stage state, index READ_LAT-1 is the output stage.
    logic [READ_LAT-1:0] valid_q, valid_d;
    logic [READ_LAT-1:0] fault_q, fault_d;
    logic [DATA_W-1:0]   instr_q [READ_LAT];
    logic [DATA_W-1:0]   instr_d [READ_LAT];
    logic [PC_W-1:0]     pc_q    [READ_LAT];
    logic [PC_W-1:0]     pc_d    [READ_LAT];

    logic              stall;
    logic              req_ready;
    logic              accept;
    logic [IdxW-1:0]   rd_idx;
    logic              rd_fault;
    logic [DATA_W-1:0] rd_instr;

    assign bus.rsp_valid = valid_q[READ_LAT-1];
    assign bus.rsp_fault = fault_q[READ_LAT-1];
    assign bus.rsp_instr = instr_q[READ_LAT-1];
    assign bus.rsp_pc    = pc_q[READ_LAT-1];
    assign bus.req_ready = req_ready;

    // Handshake and array read for the request presented this cycle.
    always_comb begin
        stall     = valid_q[READ_LAT-1] & ~bus.rsp_ready;
        // Loads and flushes take the cycle; the output stage must be free to move.
        req_ready = ~stall & ~ld_en & ~flush & rst_n;
        accept    = bus.req_valid & req_ready;
        rd_idx    = bus.req_pc[IdxW+1:2];
        // Any PC bit above the word index means the PC is beyond the array.
        rd_fault  = (bus.req_pc[1:0] != 2'b00) || ((bus.req_pc >> (IdxW + 2)) != '0);
        rd_instr  = rd_fault ? NOP_WORD : mem_q[rd_idx];
    end

    // Next state of the pipeline: flush clears, stall holds, otherwise shift by one.
    always_comb begin
        valid_d = valid_q;
        fault_d = fault_q;
        instr_d = instr_q;
        pc_d    = pc_q;
        if (flush) begin
            valid_d = '0;
        end else if (!stall) begin
            valid_d[0] = accept;
            if (accept) begin
                fault_d[0] = rd_fault;
                instr_d[0] = rd_instr;
                pc_d[0]    = bus.req_pc;
            end
            for (int unsigned i = 1; i < READ_LAT; i++) begin
                valid_d[i] = valid_q[i-1];
                fault_d[i] = fault_q[i-1];
                instr_d[i] = instr_q[i-1];
                pc_d[i]    = pc_q[i-1];
            end
        end
    end

    // Pipeline registers; reset drops every in-flight fetch immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            fault_q <= '0;
            for (int unsigned i = 0; i < READ_LAT; i++) begin
                instr_q[i] <= '0;
                pc_q[i]    <= '0;
            end
        end else begin
            valid_q <= valid_d;
            fault_q <= fault_d;
            instr_q <= instr_d;
            pc_q    <= pc_d;
        end
    end

    // Program load port; runs regardless of stall or flush.
    always_ff @(posedge clk) begin
        if (ld_en) begin
            mem_q[ld_addr] <= ld_data;
        end
    end

endmodule
